// File: rtl/alu_iterative.sv
// WIDTH-bit ALU: logic/ADD/SUB (and DIV by zero) in 1 cycle, MUL/DIV radix-2 iterative in WIDTH+1 cycles.
// Valid/ready on both sides; results and flags hold in DONE until out_ready, inputs ignored meanwhile.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             unsig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             div_zero
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_S = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opb;
  logic             r_is_mul, r_signed, r_neg_q, r_neg_r, r_dovf;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_overflow, r_div_zero;

  logic             w_accept, w_iter;
  logic [WIDTH-1:0] w_abs_a, w_abs_b, w_sum, w_diff;
  logic [WIDTH-1:0] w_res, w_res_hi;
  logic             w_ovf, w_dz;
  logic [WIDTH:0]   w_madd, w_rem_sh, w_trial;
  logic [WIDTH-1:0] w_step_hi, w_step_lo, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic             w_mul_ovf;

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign overflow  = r_overflow;
  assign div_zero  = r_div_zero;

  assign w_accept = in_valid & in_ready;
  assign w_iter   = (op == 3'b111) | ((op == 3'b011) & (b != '0));
  assign w_abs_a  = (!unsig && a[WIDTH-1]) ? -a : a;
  assign w_abs_b  = (!unsig && b[WIDTH-1]) ? -b : b;
  assign w_sum    = a + b;
  assign w_diff   = a - b;

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_ovf    = 1'b0;
    w_dz     = 1'b0;
    case (op)
      3'b000: w_res = a & b;
      3'b001: w_res = a | b;
      3'b010: begin
        w_res = w_sum;
        w_ovf = !unsig && (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b011: begin
        w_res    = '1;
        w_res_hi = a;
        w_dz     = 1'b1;
      end
      3'b100: w_res = ~(a | b);
      3'b101: w_res = a ^ b;
      3'b110: begin
        w_res = w_diff;
        w_ovf = !unsig && (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
  end

  // MUL: {r_hi,r_lo} shifts right with the partial sum; DIV: restoring step, quotient bits enter r_lo
  assign w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
  assign w_rem_sh = {r_hi, r_lo[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_opb};
  assign w_step_hi = r_is_mul ? w_madd[WIDTH:1]
                              : (w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0]);
  assign w_step_lo = r_is_mul ? {w_madd[0], r_lo[WIDTH-1:1]}
                              : {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};

  assign w_prod    = {w_step_hi, w_step_lo};
  assign w_prod_s  = r_neg_q ? -w_prod : w_prod;
  assign w_quo     = r_neg_q ? -w_step_lo : w_step_lo;
  assign w_rem     = r_neg_r ? -w_step_hi : w_step_hi;
  assign w_mul_ovf = r_signed ? (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}})
                              : (w_prod_s[2*WIDTH-1:WIDTH] != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opb       <= '0;
      r_is_mul    <= 1'b0;
      r_signed    <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dovf      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_overflow  <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        S_BUSY: begin
          r_hi  <= w_step_hi;
          r_lo  <= w_step_lo;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST) begin
            r_state    <= S_DONE;
            r_div_zero <= 1'b0;
            if (r_is_mul) begin
              r_result    <= w_prod_s[WIDTH-1:0];
              r_result_hi <= w_prod_s[2*WIDTH-1:WIDTH];
              r_overflow  <= w_mul_ovf;
            end else begin
              r_result    <= w_quo;
              r_result_hi <= w_rem;
              r_overflow  <= r_dovf;
            end
          end
        end
        default: begin
          if (w_accept) begin
            if (w_iter) begin
              r_state  <= S_BUSY;
              r_cnt    <= '0;
              r_hi     <= '0;
              r_is_mul <= op[2];
              r_lo     <= op[2] ? w_abs_b : w_abs_a;
              r_opb    <= op[2] ? w_abs_a : w_abs_b;
              r_signed <= !unsig;
              r_neg_q  <= !unsig && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg_r  <= !unsig && a[WIDTH-1];
              r_dovf   <= !unsig && !op[2] && (a == MIN_S) && (b == '1);
            end else begin
              r_state     <= S_DONE;
              r_result    <= w_res;
              r_result_hi <= w_res_hi;
              r_overflow  <= w_ovf;
              r_div_zero  <= w_dz;
            end
          end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative (WIDTH=32): directed cases plus random ops against a 64-bit arithmetic model.
module tb_alu_iterative;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, unsig, out_valid, out_ready, overflow, div_zero;
  logic [31:0] a, b, result, result_hi;
  logic [2:0]  op;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_ADD = 3'b010, OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100, OP_XOR = 3'b101, OP_SUB = 3'b110, OP_MUL = 3'b111;

  alu_iterative #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .unsig(unsig), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .overflow(overflow), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference computed with wide signed/unsigned arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic u, output logic [31:0] r, output logic [31:0] rh,
                                output logic ov, output logic dz);
    longint sx, sy, s, q, m;
    logic [63:0] pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; rh = '0; ov = 1'b0; dz = 1'b0;
    case (o)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_NOR: r = ~(x | y);
      OP_XOR: r = x ^ y;
      OP_ADD, OP_SUB: begin
        s = (o == OP_ADD) ? sx + sy : sx - sy;
        r = s[31:0];
        ov = !u && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      OP_MUL: begin
        if (u) begin
          pu = {32'd0, x} * {32'd0, y};
          r = pu[31:0]; rh = pu[63:32]; ov = (pu[63:32] != 0);
        end else begin
          s = sx * sy;
          r = s[31:0]; rh = s[63:32];
          ov = (s > 64'sd2147483647 || s < -64'sd2147483648);
        end
      end
      default: begin
        if (y == 0) begin
          r = '1; rh = x; dz = 1'b1;
        end else if (u) begin
          r = x / y; rh = x % y;
        end else begin
          q = sx / sy; m = sx % sy;
          r = q[31:0]; rh = m[31:0];
          ov = (q > 64'sd2147483647);
        end
      end
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic u);
    logic [31:0] er, erh;
    logic eov, edz;
    int lat, exp_lat, guard;
    model(o, x, y, u, er, erh, eov, edz);
    exp_lat = (o == OP_MUL || (o == OP_DIV && y != 0)) ? 33 : 1;
    @(negedge clock);
    out_ready = 1'b1; in_valid = 1'b1; op = o; a = x; b = y; unsig = u;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!in_ready) chk({tag, "_rdy_timeout"}, 0, 1);
    @(posedge clock);
    lat = 0;
    forever begin
      @(negedge clock);
      lat++;
      if (out_valid || lat >= 100) begin
        in_valid = 1'b0;
        break;
      end
      // busy: garbage inputs must be ignored
      chk({tag, "_busy_rdy"}, in_ready, 0);
      in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, er);
    chk({tag, "_hi"}, result_hi, erh);
    chk({tag, "_ovf"}, overflow, eov);
    chk({tag, "_dz"}, div_zero, edz);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] er, erh, xr, sums[8];
    logic eov, edz;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0; unsig = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rst_ovld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_flags", {overflow, div_zero}, 0);
    chk("rst_rdy", in_ready, 1);

    run_op("add_s_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
    run_op("add_u", OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b1);
    run_op("sub_s_ovf", OP_SUB, 32'h80000000, 32'h1, 1'b0);
    run_op("mul_s", OP_MUL, 32'hFFFFFFFD, 32'h5, 1'b0);
    run_op("mul_u_ovf", OP_MUL, 32'h00010000, 32'h00010000, 1'b1);
    run_op("div_s", OP_DIV, 32'hFFFFFFF9, 32'h2, 1'b0);
    run_op("div_min", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op("div_zero", OP_DIV, 32'h7, 32'h0, 1'b1);
    run_op("nor", OP_NOR, 32'h0F0F0000, 32'h000000FF, 1'b0);

    // back-pressure: result held while out_ready low, pending op waits
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; op = OP_XOR; a = 32'hDEADBEEF; b = 32'h12345678; unsig = 1'b0;
    xr = 32'hDEADBEEF ^ 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    op = OP_ADD; a = 32'd100; b = 32'd23;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ovld", out_valid, 1);
      chk("bp_res", result, xr);
      chk("bp_rdy", in_ready, 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    #1 chk("bp_rdy_up", in_ready, 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    chk("bp_new_ovld", out_valid, 1);
    chk("bp_new_res", result, 32'd123);

    // throughput: 8 back-to-back ADDs
    @(negedge clock);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        chk("tp_ovld", out_valid, 1);
        chk("tp_res", result, sums[i-1]);
      end
      if (i < 8) begin
        chk("tp_rdy", in_ready, 1);
        in_valid = 1'b1; op = OP_ADD; unsig = 1'b1; a = $urandom; b = $urandom;
        model(OP_ADD, a, b, 1'b1, er, erh, eov, edz);
        sums[i] = er;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clock);
    end

    // reset on the 10th busy cycle of a MUL
    in_valid = 1'b1; op = OP_MUL; a = 32'h1234; b = 32'h5678; unsig = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("rstb_ovld", out_valid, 0);
    chk("rstb_res", result, 0);
    chk("rstb_rdy", in_ready, 1);
    repeat (40) begin
      @(negedge clock);
      if (out_valid) break;
    end
    chk("rstb_no_ovld", out_valid, 0);
    run_op("and_after_rst", OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0);

    for (int i = 0; i < 150; i++)
      run_op("rand", 3'($urandom), pick(), pick(), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
